// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer melody sequencer.
//   - tone codes driven onto the tone generator's select input
//   - melody ROM entry layout {tone, dur}; dur == 0 terminates a melody
//   - melody count / length constants and the sequencer state enum
package buzzer_pkg;

    localparam logic [3:0] MUTE  = 4'd0;
    localparam logic [3:0] DO    = 4'd1;
    localparam logic [3:0] RE    = 4'd2;
    localparam logic [3:0] MI    = 4'd3;
    localparam logic [3:0] FA    = 4'd4;
    localparam logic [3:0] SO    = 4'd5;
    localparam logic [3:0] LA    = 4'd6;
    localparam logic [3:0] TI    = 4'd7;
    localparam logic [3:0] HI_DO = 4'd8;

    localparam int NUM_MELODIES = 2;
    localparam int MEL_LEN      = 8;
    localparam int MEL_W        = 1;   // bits of melody id
    localparam int IDX_W        = 3;   // bits of entry index (plus a separate end flag)

    typedef struct packed {
        logic [3:0] tone;
        logic [3:0] dur;    // note length in duration units; 0 = terminator
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic entry_t mk_entry(input logic [3:0] tone, input logic [3:0] dur);
        entry_t e;
        e.tone = tone;
        e.dur  = dur;
        return e;
    endfunction

endpackage

// File: rtl/buzzer_melody_rom.sv
// Built-in melody table, purely combinational.
//   mel_i : melody id
//   idx_i : entry index within the melody
//   ent_o : {tone, dur} at that position
module buzzer_melody_rom
    import buzzer_pkg::*;
(
    input  logic [MEL_W-1:0] mel_i,
    input  logic [IDX_W-1:0] idx_i,
    output entry_t           ent_o
);

    always_comb begin
        ent_o = mk_entry(MUTE, 4'd0);
        if (mel_i == 1'b0) begin
            // Rising arpeggio Do-Mi-So-HiDo, then terminator.
            case (idx_i)
                3'd0:    ent_o = mk_entry(DO,    4'd2);
                3'd1:    ent_o = mk_entry(MI,    4'd2);
                3'd2:    ent_o = mk_entry(SO,    4'd2);
                3'd3:    ent_o = mk_entry(HI_DO, 4'd2);
                default: ent_o = mk_entry(MUTE,  4'd0);
            endcase
        end else begin
            // Alarm beeps: HiDo / rest alternating over all 8 slots, no terminator.
            ent_o = idx_i[0] ? mk_entry(MUTE, 4'd1) : mk_entry(HI_DO, 4'd1);
        end
    end

endmodule

// File: rtl/buzzer_melody_seq.sv
// Melody sequencer and two-requester arbiter feeding the buzzer tone generator.
//   clk, rst_n    : clock, synchronous active-low reset
//   play_req_i[n] : one-cycle request for melody n (bit 1 wins)
//   abort_i       : stop playback and drop pending requests
//   play_ack_o[n] : one-cycle pulse when melody n starts
//   tone_sel_o    : tone code to the generator (0 = mute)
//   busy_o        : a melody is in PLAY or GAP
//   done_o        : one-cycle pulse on normal completion
//   done_id_o     : melody that completed, held until the next done
module buzzer_melody_seq
    import buzzer_pkg::*;
#(
    parameter int unsigned HOST_HZ  = 100_000_000,
    parameter int unsigned UNIT_CYC = HOST_HZ / 16,
    parameter int unsigned GAP_CYC  = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] play_req_i,
    input  logic       abort_i,
    output logic [1:0] play_ack_o,
    output logic [3:0] tone_sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       done_id_o
);

    localparam int unsigned CYC_MAX = (UNIT_CYC > GAP_CYC) ? UNIT_CYC : GAP_CYC;
    localparam int CYC_W = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam logic [CYC_W-1:0] UNIT_LAST = CYC_W'(UNIT_CYC - 1);
    localparam logic [CYC_W-1:0] GAP_LAST  = CYC_W'(GAP_CYC - 1);

    state_e             state_q, state_d;
    logic [MEL_W-1:0]   mel_q, mel_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [3:0]         unit_q, unit_d;
    entry_t             ent_q, ent_d;
    logic [1:0]         pend_q, pend_d;
    logic [3:0]         tone_q, tone_d;
    logic               busy_q, busy_d;
    logic [1:0]         ack_q, ack_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;

    logic               go;
    logic [MEL_W-1:0]   go_mel;
    logic               fin;
    entry_t             start_ent, nxt_ent;
    logic               nxt_end;
    logic [IDX_W-1:0]   nxt_idx;

    // Index increment carries into an end flag instead of wrapping to 0.
    assign {nxt_end, nxt_idx} = {1'b0, idx_q} + {{IDX_W{1'b0}}, 1'b1};

    buzzer_melody_rom u_rom_start (
        .mel_i (go_mel),
        .idx_i ({IDX_W{1'b0}}),
        .ent_o (start_ent)
    );

    buzzer_melody_rom u_rom_next (
        .mel_i (mel_q),
        .idx_i (nxt_idx),
        .ent_o (nxt_ent)
    );

    // Arbiter: decides whether a melody (re)starts this cycle and updates the
    // one-deep pending latches. Melody 1 may cut into melody 0; everything
    // else waits for IDLE.
    always_comb begin
        go     = 1'b0;
        go_mel = 1'b0;
        pend_d = pend_q;
        if (abort_i) begin
            pend_d = 2'b00;
        end else if (state_q != ST_IDLE) begin
            if (play_req_i[1] && mel_q == 1'b0) begin
                go     = 1'b1;
                go_mel = 1'b1;
            end else if (play_req_i[1]) begin
                pend_d[1] = 1'b1;
            end
            if (play_req_i[0]) pend_d[0] = 1'b1;
        end else if (play_req_i[1] || pend_q[1]) begin
            go        = 1'b1;
            go_mel    = 1'b1;
            pend_d[1] = 1'b0;
            if (play_req_i[0]) pend_d[0] = 1'b1;
        end else if (play_req_i[0] || pend_q[0]) begin
            go        = 1'b1;
            go_mel    = 1'b0;
            pend_d[0] = 1'b0;
        end
    end

    // FSM state register plus datapath flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mel_q     <= '0;
            idx_q     <= '0;
            cyc_q     <= '0;
            unit_q    <= '0;
            ent_q     <= '0;
            pend_q    <= '0;
            tone_q    <= MUTE;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mel_q     <= mel_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            unit_q    <= unit_d;
            ent_q     <= ent_d;
            pend_q    <= pend_d;
            tone_q    <= tone_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    // Next state. ent_q caches the entry being played so only the
    // look-ahead entry needs a ROM port during playback.
    always_comb begin
        state_d = state_q;
        mel_d   = mel_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        unit_d  = unit_q;
        ent_d   = ent_q;
        fin     = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else if (go) begin
            mel_d  = go_mel;
            idx_d  = '0;
            cyc_d  = '0;
            unit_d = '0;
            ent_d  = start_ent;
            if (start_ent.dur == 4'd0) begin
                state_d = ST_IDLE;
                fin     = 1'b1;
            end else begin
                state_d = ST_PLAY;
            end
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (cyc_q == UNIT_LAST) begin
                        cyc_d = '0;
                        if (unit_q == ent_q.dur - 4'd1) begin
                            unit_d = '0;
                            // Last note: no trailing gap, finish straight away.
                            if (nxt_end || nxt_ent.dur == 4'd0) begin
                                state_d = ST_IDLE;
                                fin     = 1'b1;
                            end else begin
                                state_d = ST_GAP;
                            end
                        end else begin
                            unit_d = unit_q + 4'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cyc_q == GAP_LAST) begin
                        cyc_d   = '0;
                        idx_d   = nxt_idx;
                        ent_d   = nxt_ent;
                        state_d = ST_PLAY;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs, registered from next-state values so they line up with state.
    always_comb begin
        tone_d    = (state_d == ST_PLAY) ? ent_d.tone : MUTE;
        busy_d    = (state_d != ST_IDLE);
        ack_d     = 2'b00;
        if (go && !abort_i) ack_d[go_mel] = 1'b1;
        done_d    = fin;
        done_id_d = fin ? mel_d : done_id_q;
    end

    assign play_ack_o = ack_q;
    assign tone_sel_o = tone_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign done_id_o  = done_id_q;

endmodule

// File: tb/tb_buzzer_melody_seq.sv
// Directed bench for buzzer_melody_seq with a time-based behavioural model.
module tb_buzzer_melody_seq;

    localparam int U = 10;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] play_req_i;
    logic       abort_i;
    logic [1:0] play_ack_o;
    logic [3:0] tone_sel_o;
    logic       busy_o;
    logic       done_o;
    logic       done_id_o;

    buzzer_melody_seq #(.HOST_HZ(160), .UNIT_CYC(U), .GAP_CYC(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_req_i (play_req_i),
        .abort_i    (abort_i),
        .play_ack_o (play_ack_o),
        .tone_sel_o (tone_sel_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .done_id_o  (done_id_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cur_sc = 0;

    // Melody content as the bench understands it.
    int rom_tone [2][8] = '{'{1, 3, 5, 8, 0, 0, 0, 0}, '{8, 0, 8, 0, 8, 0, 8, 0}};
    int rom_dur  [2][8] = '{'{2, 2, 2, 2, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 1}};

    function automatic int mel_len(input logic m);
        int total = 0;
        for (int k = 0; k < 8; k++) begin
            if (rom_dur[m][k] == 0) break;
            if (k > 0) total += G;
            total += rom_dur[m][k] * U;
        end
        return total;
    endfunction

    function automatic int tone_at(input logic m, input int t);
        int r = t;
        for (int k = 0; k < 8; k++) begin
            if (rom_dur[m][k] == 0) return 0;
            if (r < rom_dur[m][k] * U) return rom_tone[m][k];
            r -= rom_dur[m][k] * U;
            if (r < G) return 0;
            r -= G;
        end
        return 0;
    endfunction

    // Model: melody id + elapsed cycles since its start.
    logic       m_play = 1'b0;
    logic       m_mel = 1'b0;
    int         m_t = 0;
    logic [1:0] m_pend = 2'b00;
    logic [1:0] m_ack = 2'b00;
    logic       m_done = 1'b0;
    logic       m_done_id = 1'b0;

    always @(posedge clk) begin
        logic go;
        logic gm;
        m_ack  = 2'b00;
        m_done = 1'b0;
        go = 1'b0;
        gm = 1'b0;
        if (!rst_n) begin
            m_play = 1'b0; m_mel = 1'b0; m_t = 0; m_pend = 2'b00; m_done_id = 1'b0;
        end else if (abort_i) begin
            m_play = 1'b0;
            m_pend = 2'b00;
        end else begin
            if (m_play) begin
                if (play_req_i[1] && m_mel == 1'b0) begin go = 1'b1; gm = 1'b1; end
                else if (play_req_i[1]) m_pend[1] = 1'b1;
                if (play_req_i[0]) m_pend[0] = 1'b1;
            end else begin
                if (play_req_i[1] || m_pend[1]) begin
                    go = 1'b1; gm = 1'b1; m_pend[1] = 1'b0;
                    if (play_req_i[0]) m_pend[0] = 1'b1;
                end else if (play_req_i[0] || m_pend[0]) begin
                    go = 1'b1; gm = 1'b0; m_pend[0] = 1'b0;
                end
            end
            if (go) begin
                m_play = 1'b1; m_mel = gm; m_t = 0; m_ack[gm] = 1'b1;
            end else if (m_play) begin
                if (m_t + 1 == mel_len(m_mel)) begin
                    m_play = 1'b0; m_done = 1'b1; m_done_id = m_mel;
                end else begin
                    m_t++;
                end
            end
        end
    end

    task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s sc=%0d cyc=%0d got=%0h want=%0h", nm, cur_sc, c, act, exp);
        end
    endtask

    // {reset, abort, req[1:0]} applied during cycle c of scenario sc.
    function automatic logic [3:0] stim(input int sc, input int c);
        case (sc)
            0: if (c == 0) return 4'b0001;
            1: begin if (c == 0) return 4'b0001; if (c == 30) return 4'b0010; end
            2: begin if (c == 0) return 4'b0001; if (c == 10) return 4'b0001; end
            3: if (c == 0) return 4'b0011;
            4: begin
                if (c == 0)  return 4'b0001;
                if (c == 40) return 4'b0010;
                if (c == 45) return 4'b0001;
                if (c == 50) return 4'b0101;
            end
            5: begin
                if (c == 0)  return 4'b0001;
                if (c == 50) return 4'b1000;
                if (c == 60) return 4'b0001;
            end
            6: begin
                if (c == 0) return 4'b0011;
                if (c == 5) return 4'b0010;
                if (c == 6) return 4'b0010;
                if (c == 7) return 4'b0001;
            end
            default: ;
        endcase
        return 4'b0000;
    endfunction

    task automatic run_sc(input int sc, input int len);
        logic [3:0] s;
        int done_cnt = 0;
        int ack_cnt = 0;
        int late_evt = 0;
        int exp_tone;
        cur_sc = sc;
        @(negedge clk);
        rst_n = 1'b0; play_req_i = 2'b00; abort_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < len; c++) begin
            s = stim(sc, c);
            rst_n      = ~s[3];
            abort_i    = s[2];
            play_req_i = s[1:0];

            exp_tone = m_play ? tone_at(m_mel, m_t) : 0;
            chk("tone",    c, 8'(tone_sel_o), 8'(exp_tone));
            chk("busy",    c, 8'(busy_o),     8'(m_play));
            chk("ack",     c, 8'(play_ack_o), 8'(m_ack));
            chk("done",    c, 8'(done_o),     8'(m_done));
            chk("done_id", c, 8'(done_id_o),  8'(m_done_id));

            if (done_o) done_cnt++;
            if (play_ack_o != 2'b00) ack_cnt++;
            if (sc == 4 && c > 51 && (done_o || play_ack_o != 2'b00)) late_evt++;

            case (sc)
                0: begin
                    if (c == 0)  begin chk("rst_tone", c, 8'(tone_sel_o), 8'd0); chk("rst_busy", c, 8'(busy_o), 8'd0); end
                    if (c == 1)  begin chk("s0_ack", c, 8'(play_ack_o), 8'h1); chk("s0_t1", c, 8'(tone_sel_o), 8'd1); end
                    if (c == 20) chk("s0_t20", c, 8'(tone_sel_o), 8'd1);
                    if (c == 21) chk("s0_gap", c, 8'(tone_sel_o), 8'd0);
                    if (c == 23) chk("s0_t23", c, 8'(tone_sel_o), 8'd3);
                    if (c == 45) chk("s0_t45", c, 8'(tone_sel_o), 8'd5);
                    if (c == 86) chk("s0_t86", c, 8'(tone_sel_o), 8'd8);
                    if (c == 87) begin
                        chk("s0_done", c, 8'(done_o), 8'd1);
                        chk("s0_id",   c, 8'(done_id_o), 8'd0);
                        chk("s0_busy", c, 8'(busy_o), 8'd0);
                    end
                end
                1: begin
                    if (c == 31)  begin chk("s1_ack", c, 8'(play_ack_o), 8'h2); chk("s1_tone", c, 8'(tone_sel_o), 8'd8); end
                    if (c == 125) begin chk("s1_done", c, 8'(done_o), 8'd1); chk("s1_id", c, 8'(done_id_o), 8'd1); end
                end
                2: if (c == 88) begin chk("s2_ack", c, 8'(play_ack_o), 8'h1); chk("s2_tone", c, 8'(tone_sel_o), 8'd1); end
                3: begin
                    if (c == 1)  chk("s3_ack1", c, 8'(play_ack_o), 8'h2);
                    if (c == 95) begin chk("s3_done", c, 8'(done_o), 8'd1); chk("s3_id", c, 8'(done_id_o), 8'd1); end
                    if (c == 96) chk("s3_ack0", c, 8'(play_ack_o), 8'h1);
                end
                4: if (c == 51) begin chk("s4_tone", c, 8'(tone_sel_o), 8'd0); chk("s4_busy", c, 8'(busy_o), 8'd0); end
                5: begin
                    if (c == 51) begin
                        chk("s5_tone", c, 8'(tone_sel_o), 8'd0);
                        chk("s5_busy", c, 8'(busy_o), 8'd0);
                        chk("s5_ack",  c, 8'(play_ack_o), 8'd0);
                    end
                    if (c == 61) chk("s5_ack0", c, 8'(play_ack_o), 8'h1);
                end
                6: begin
                    if (c == 96)  chk("s6_ack1", c, 8'(play_ack_o), 8'h2);
                    if (c == 191) chk("s6_ack0", c, 8'(play_ack_o), 8'h1);
                    if (c == 277) begin chk("s6_done", c, 8'(done_o), 8'd1); chk("s6_id", c, 8'(done_id_o), 8'd0); end
                end
                default: ;
            endcase
            @(negedge clk);
        end
        if (sc == 1) chk("s1_done_cnt", len, 8'(done_cnt), 8'd1);
        if (sc == 4) chk("s4_no_late", len, 8'(late_evt), 8'd0);
        if (sc == 6) chk("s6_ack_cnt", len, 8'(ack_cnt), 8'd3);
    endtask

    initial begin
        rst_n = 1'b0;
        play_req_i = 2'b00;
        abort_i = 1'b0;
        run_sc(0, 100);
        run_sc(1, 140);
        run_sc(2, 180);
        run_sc(3, 200);
        run_sc(4, 120);
        run_sc(5, 160);
        run_sc(6, 300);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
